tx_interrupt_gen: RTL and testbench
===================================

# tx_interrupt_gen

Host interrupt generator for the TX DMA path, sitting between the TX completion logic and the Virtex-5 PCIe endpoint `cfg_interrupt` interface. It counts frames whose DMA read has completed. Once the matching completion write to host memory has been acknowledged, it raises an interrupt. Interrupts are coalesced by frame count or by timeout, and a programmable minimum gap is enforced between interrupts. A driver-requested resend is also supported.

## Interface
Parameters:
- `PEND_W`, 16: width of the pending-frame counter and of `coalesce_count`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `cfg_interrupt_n`  out  1  interrupt request to the endpoint, active-low
- `cfg_interrupt_rdy_n`  in  1  endpoint accepted the request, active-low
- `tx_frame_done`  in  1  single-cycle pulse per frame fully read by DMA
- `tx_completion_wr`  in  1  completion-pointer write to host issued
- `tx_completion_wr_ack`  in  1  completion-pointer write accepted by TLP engine
- `interrupts_enabled`  in  1  driver interrupt enable
- `interrupt_period`  in  32  minimum gap cycles after each interrupt
- `coalesce_count`  in  `PEND_W`  frame threshold; 0 treated as 1
- `coalesce_timeout`  in  32  cycles a non-zero pending count may wait before firing
- `resend_interrupt`  in  1  driver request to re-raise the interrupt
- `resend_interrupt_ack`  out  1  single-cycle acknowledge of resend
- `pending_frames`  out  `PEND_W`  frames not yet covered by an interrupt (status)

## Operation
- **Pending counter.** Saturating increment on `tx_frame_done`.
- **Written flag.** Set when `tx_completion_wr && tx_completion_wr_ack`.
- **Timer.** Increments each cycle while `pending_frames != 0`. Clears when the pending count is zero or on fire. Saturates at all-ones.
- **Fire condition**, evaluated in IDLE only, on registered values: `written && pending_frames != 0 && (pending_frames >= max(coalesce_count,1) || timer >= coalesce_timeout)`.
- **On fire:**
  - `pending_frames` is cleared to 0, or set to 1 if `tx_frame_done` is high in the same cycle.
  - `written` and the timer clear.
  - Next state is ASSERT if `interrupts_enabled`, else GAP.
- **FSM states** (one-hot):
  - IDLE: fire → ASSERT/GAP. Else if `resend_interrupt`: pulse `resend_interrupt_ack`, go to RESEND. Fire has priority over resend.
  - ASSERT: drive `cfg_interrupt_n`=0. When `cfg_interrupt_rdy_n`=0, drive `cfg_interrupt_n`=1 the next cycle and go to GAP.
  - GAP: counter starts at 0 and increments each cycle. When counter == `interrupt_period_q`, go to IDLE (`interrupt_period`+1 cycles in GAP).
  - RESEND: wait for `interrupts_enabled`, then go to ASSERT. No timeout.
  - Illegal/unused encoding → IDLE.
- **`interrupt_period` handling.** The input is registered each cycle into `interrupt_period_q`; GAP compares against the registered copy.
- **Accounting while busy.** Frames and completion writes arriving during ASSERT, GAP or RESEND still accumulate and are evaluated on return to IDLE.
- **Interrupts disabled.** When `interrupts_enabled`=0 at fire time, pending is still consumed and GAP still runs, so the driver polls.

## Timing
- Reset values: `cfg_interrupt_n`=1, `resend_interrupt_ack`=0, `pending_frames`=0, written=0, timer=0, FSM=IDLE.
- `tx_frame_done` at cycle t appears in `pending_frames` at t+1.
- Fire latency: if the last qualifying input (frame pulse or write ack) occurs at t, `cfg_interrupt_n` goes low at t+2.
- `cfg_interrupt_n` stays low until `cfg_interrupt_rdy_n` is sampled low, then is high the following cycle. It is never re-asserted before GAP completes.
- A frame and a write ack in the same cycle are both recorded.
- Reset mid-ASSERT forces `cfg_interrupt_n`=1 on the next edge. All counts are discarded.
- Counter saturation at 2^`PEND_W`−1 holds the value; no wrap.

## Configuration
- `TX_INT_COALESCE_EN` defined: fire condition as above, with count threshold and timeout.
- Not defined:
  - `coalesce_count` and `coalesce_timeout` are ignored and the timer is not built.
  - Fire condition becomes `written && pending_frames != 0`.
  - One interrupt per completion write, throttled only by `interrupt_period`.

## Structure
- Shared package `tx_int_pkg`: one-hot state constants (IDLE, ASSERT, GAP, RESEND) and the `PEND_W` default.
- Sub-module `tx_int_coalescer`: pending counter, written flag, timer and fire decision. Outputs `fire` and `pending_frames`, takes a `consume` input. The top level holds the FSM and the endpoint handshake.

## Test plan
- 3 `tx_frame_done` pulses, `coalesce_count`=4, `coalesce_timeout`=1000, then write ack → no interrupt until timer reaches 1000; `cfg_interrupt_n` low 2 cycles later; `pending_frames`→0.
- 4 pulses plus write ack at cycle 10, `coalesce_count`=4 → `cfg_interrupt_n` low at cycle 12; `cfg_interrupt_rdy_n` low at 15 → high at 16.
- `interrupt_period`=20, a second fire condition met during GAP → next assertion no earlier than 21 cycles after GAP entry.
- `interrupts_enabled`=0 at fire → `cfg_interrupt_n` stays 1; pending cleared; then `resend_interrupt`=1 → ack pulse 1 cycle; enable at +5 → `cfg_interrupt_n` low next cycle.
- Reset asserted while `cfg_interrupt_n`=0 → `cfg_interrupt_n`=1 and `pending_frames`=0 after one edge.
- 65 540 pulses with no write ack → `pending_frames` saturates at 65 535.

Source files
------------

// File: rtl/tx_int_pkg.sv
// Shared definitions for the TX interrupt generator: one-hot FSM encoding
// and the default pending-counter width.
package tx_int_pkg;

   localparam int PEND_W_DEFAULT = 16;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_ASSERT = 4'b0010,
      ST_GAP    = 4'b0100,
      ST_RESEND = 4'b1000
   } state_t;

endpackage

// File: rtl/tx_interrupt_gen_if.sv
// Endpoint legacy-interrupt handshake (cfg_interrupt_n / cfg_interrupt_rdy_n).
// master = interrupt generator, slave = PCIe endpoint.
interface tx_interrupt_gen_if;
   logic cfg_interrupt_n;
   logic cfg_interrupt_rdy_n;

   modport master (output cfg_interrupt_n, input cfg_interrupt_rdy_n);
   modport slave  (input cfg_interrupt_n, output cfg_interrupt_rdy_n);
endinterface

// File: rtl/tx_int_coalescer.sv
// Pending-frame accounting and fire decision for tx_interrupt_gen.
// TX_INT_COALESCE_EN: when defined, fire waits for a frame-count threshold
// or a timeout; when undefined, every acknowledged completion write with
// pending frames fires and the timer is not built.
module tx_int_coalescer
   import tx_int_pkg::*;
#(
   parameter int PEND_W = PEND_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_frame_done,
   input  logic              tx_completion_wr,
   input  logic              tx_completion_wr_ack,
   input  logic [PEND_W-1:0] coalesce_count,
   input  logic [31:0]       coalesce_timeout,
   input  logic              consume,
   output logic              fire,
   output logic [PEND_W-1:0] pending_frames
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

   logic [PEND_W-1:0] pending_q;
   logic              written_q;

   // Saturating frame count; a frame arriving on the consume cycle is kept.
   always_ff @(posedge clk) begin
      if (reset)
         pending_q <= '0;
      else if (consume)
         pending_q <= {{(PEND_W-1){1'b0}}, tx_frame_done};
      else if (tx_frame_done && (pending_q != PEND_MAX))
         pending_q <= pending_q + PEND_ONE;
   end

   // Remembers that the host-visible completion pointer has been written.
   always_ff @(posedge clk) begin
      if (reset || consume)
         written_q <= 1'b0;
      else if (tx_completion_wr && tx_completion_wr_ack)
         written_q <= 1'b1;
   end

`ifdef TX_INT_COALESCE_EN
   logic [31:0]       timer_q;
   logic [PEND_W-1:0] thresh;

   // Age of the oldest uncovered frame; saturates rather than wraps.
   always_ff @(posedge clk) begin
      if (reset || consume || (pending_q == '0))
         timer_q <= '0;
      else if (timer_q != '1)
         timer_q <= timer_q + 32'd1;
   end

   assign thresh = (coalesce_count == '0) ? PEND_ONE : coalesce_count;
   assign fire   = written_q && (pending_q != '0) &&
                   ((pending_q >= thresh) || (timer_q >= coalesce_timeout));
`else
   logic unused_coalesce_cfg;
   assign unused_coalesce_cfg = ^{coalesce_count, coalesce_timeout};
   assign fire = written_q && (pending_q != '0);
`endif

   assign pending_frames = pending_q;

endmodule

// File: rtl/tx_interrupt_gen.sv
// TX DMA host interrupt generator: sequences the endpoint interrupt
// handshake, enforces a minimum gap after each interrupt and services
// driver resend requests. Coalescing is enabled by TX_INT_COALESCE_EN.
//
// state     | meaning
// ST_IDLE   | waiting for fire or a resend request
// ST_ASSERT | cfg_interrupt_n low until the endpoint accepts
// ST_GAP    | hold-off for interrupt_period+1 cycles
// ST_RESEND | resend acknowledged, waiting for interrupts_enabled
module tx_interrupt_gen
   import tx_int_pkg::*;
#(
   parameter int PEND_W = PEND_W_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   tx_interrupt_gen_if.master  ep,
   input  logic                tx_frame_done,
   input  logic                tx_completion_wr,
   input  logic                tx_completion_wr_ack,
   input  logic                interrupts_enabled,
   input  logic [31:0]         interrupt_period,
   input  logic [PEND_W-1:0]   coalesce_count,
   input  logic [31:0]         coalesce_timeout,
   input  logic                resend_interrupt,
   output logic                resend_interrupt_ack,
   output logic [PEND_W-1:0]   pending_frames
);

   state_t      state_q, state_nxt;
   logic [31:0] period_q;
   logic [31:0] gap_cnt_q;
   logic        fire;
   logic        consume;
   logic        ack_nxt;
   logic        cfg_int_n_q;
   logic        ack_q;

   tx_int_coalescer #(.PEND_W(PEND_W)) u_coalescer (
      .clk                  (clk),
      .reset                (reset),
      .tx_frame_done        (tx_frame_done),
      .tx_completion_wr     (tx_completion_wr),
      .tx_completion_wr_ack (tx_completion_wr_ack),
      .coalesce_count       (coalesce_count),
      .coalesce_timeout     (coalesce_timeout),
      .consume              (consume),
      .fire                 (fire),
      .pending_frames       (pending_frames)
   );

   // Registered copy of the gap length so GAP compares a stable value.
   always_ff @(posedge clk) begin
      if (reset)
         period_q <= '0;
      else
         period_q <= interrupt_period;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_nxt;
   end

   // Next-state decode; fire wins over a simultaneous resend request.
   always_comb begin
      state_nxt = state_q;
      consume   = 1'b0;
      ack_nxt   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fire) begin
               consume   = 1'b1;
               state_nxt = interrupts_enabled ? ST_ASSERT : ST_GAP;
            end else if (resend_interrupt) begin
               ack_nxt   = 1'b1;
               state_nxt = ST_RESEND;
            end
         end
         ST_ASSERT: begin
            if (!ep.cfg_interrupt_rdy_n)
               state_nxt = ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt_q == period_q)
               state_nxt = ST_IDLE;
         end
         ST_RESEND: begin
            if (interrupts_enabled)
               state_nxt = ST_ASSERT;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Gap counter reads 0 on the first GAP cycle.
   always_ff @(posedge clk) begin
      if (reset || (state_q != ST_GAP))
         gap_cnt_q <= '0;
      else
         gap_cnt_q <= gap_cnt_q + 32'd1;
   end

   // Outputs registered from next-state so they track the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_int_n_q <= 1'b1;
         ack_q       <= 1'b0;
      end else begin
         cfg_int_n_q <= (state_nxt != ST_ASSERT);
         ack_q       <= ack_nxt;
      end
   end

   assign ep.cfg_interrupt_n   = cfg_int_n_q;
   assign resend_interrupt_ack = ack_q;

endmodule

// File: tb/tb_tx_interrupt_gen.sv
// Scoreboard bench for tx_interrupt_gen: stimulus pushes expected
// interrupt / deassert / resend-ack events with their cycle numbers; a
// monitor pops and compares whenever the DUT produces one.
module tb_tx_interrupt_gen;

   localparam int PEND_W = 16;

   typedef enum {EV_INT, EV_DEASSERT, EV_ACK} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       cyc;
   } ev_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              tx_frame_done = 1'b0;
   logic              tx_completion_wr = 1'b0;
   logic              tx_completion_wr_ack = 1'b0;
   logic              interrupts_enabled = 1'b1;
   logic [31:0]       interrupt_period = 32'd3;
   logic [PEND_W-1:0] coalesce_count = 16'd4;
   logic [31:0]       coalesce_timeout = 32'd1000;
   logic              resend_interrupt = 1'b0;
   logic              resend_interrupt_ack;
   logic [PEND_W-1:0] pending_frames;

   tx_interrupt_gen_if ep_if ();

   tx_interrupt_gen #(.PEND_W(PEND_W)) dut (
      .clk                  (clk),
      .reset                (reset),
      .ep                   (ep_if.master),
      .tx_frame_done        (tx_frame_done),
      .tx_completion_wr     (tx_completion_wr),
      .tx_completion_wr_ack (tx_completion_wr_ack),
      .interrupts_enabled   (interrupts_enabled),
      .interrupt_period     (interrupt_period),
      .coalesce_count       (coalesce_count),
      .coalesce_timeout     (coalesce_timeout),
      .resend_interrupt     (resend_interrupt),
      .resend_interrupt_ack (resend_interrupt_ack),
      .pending_frames       (pending_frames)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   ev_t  exp_q[$];
   logic prev_n = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, req);
      end
   endtask

   task automatic push(input ev_kind_t k, input int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic handle_ev(input ev_kind_t k);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event actual=%s@%0d required=none", k.name(), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc) begin
            n_err++;
            $display("FAIL event actual=%s@%0d required=%s@%0d", k.name(), cyc, e.kind.name(), e.cyc);
         end
      end
   endtask

   // Monitor: sample outputs 2 time units after each rising edge.
   always @(posedge clk) begin
      #2;
      if (prev_n === 1'b1 && ep_if.cfg_interrupt_n === 1'b0) handle_ev(EV_INT);
      if (prev_n === 1'b0 && ep_if.cfg_interrupt_n === 1'b1) handle_ev(EV_DEASSERT);
      if (resend_interrupt_ack === 1'b1) handle_ev(EV_ACK);
      prev_n <= ep_if.cfg_interrupt_n;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) step();
   endtask

   // Four frames, the last together with an acknowledged completion write.
   task automatic burst4(output int last);
      last = 0;
      for (int i = 0; i < 4; i++) begin
         tx_frame_done = 1'b1;
         if (i == 3) begin
            chk("burst_pending3", 32'(pending_frames), 32'd3);
            tx_completion_wr     = 1'b1;
            tx_completion_wr_ack = 1'b1;
            last = cyc;
         end
         step();
      end
      tx_frame_done        = 1'b0;
      tx_completion_wr     = 1'b0;
      tx_completion_wr_ack = 1'b0;
   endtask

   // Endpoint accepts in cycle t; cfg_interrupt_n must be high in t+1.
   task automatic ep_accept(input int t);
      wait_cyc(t);
      ep_if.cfg_interrupt_rdy_n = 1'b0;
      push(EV_DEASSERT, t + 1);
      step();
      ep_if.cfg_interrupt_rdy_n = 1'b1;
   endtask

   initial begin
      int last, a, q, t_int, x;
      ep_if.cfg_interrupt_rdy_n = 1'b1;
      step();
      step();
      chk("reset_cfg_n", 32'(ep_if.cfg_interrupt_n), 32'd1);
      chk("reset_ack", 32'(resend_interrupt_ack), 32'd0);
      chk("reset_pending", 32'(pending_frames), 32'd0);
      reset = 1'b0;
      step();
      step();

      // Count threshold reached together with the write ack.
      burst4(last);
      push(EV_INT, last + 2);
      wait_cyc(last + 2);
      chk("pending_after_fire", 32'(pending_frames), 32'd0);
      ep_accept(last + 5);
      wait_cyc(last + 12);

      // Three frames below threshold: timeout path (or immediate without coalescing).
      interrupt_period = 32'd0;
      q = cyc;
      for (int i = 0; i < 3; i++) begin
         tx_frame_done = 1'b1;
         step();
      end
      tx_frame_done = 1'b0;
      chk("three_pending", 32'(pending_frames), 32'd3);
      tx_completion_wr     = 1'b1;
      tx_completion_wr_ack = 1'b1;
      step();
      tx_completion_wr     = 1'b0;
      tx_completion_wr_ack = 1'b0;
`ifdef TX_INT_COALESCE_EN
      t_int = q + 1002;
      push(EV_INT, t_int);
      wait_cyc(q + 500);
      chk("pending_held_before_timeout", 32'(pending_frames), 32'd3);
`else
      t_int = q + 5;
      push(EV_INT, t_int);
`endif
      wait_cyc(t_int);
      chk("pending_after_timeout_fire", 32'(pending_frames), 32'd0);
      ep_accept(t_int + 1);
      wait_cyc(t_int + 6);

      // Second fire condition met during a 21-cycle gap.
      interrupt_period = 32'd20;
      step();
      step();
      burst4(last);
      a = last + 2;
      push(EV_INT, a);
      ep_accept(a + 1);
      wait_cyc(a + 4);
      burst4(last);
      push(EV_INT, a + 24);
      ep_accept(a + 26);
      wait_cyc(a + 50);
      interrupt_period = 32'd2;
      wait_cyc(a + 52);

      // Interrupts disabled at fire, then driver resend.
      interrupts_enabled = 1'b0;
      burst4(last);
      wait_cyc(last + 2);
      chk("disabled_pending_cleared", 32'(pending_frames), 32'd0);
      chk("disabled_cfg_n_high", 32'(ep_if.cfg_interrupt_n), 32'd1);
      wait_cyc(last + 7);
      resend_interrupt = 1'b1;
      x = cyc;
      push(EV_ACK, x + 1);
      step();
      resend_interrupt = 1'b0;
      wait_cyc(x + 5);
      interrupts_enabled = 1'b1;
      push(EV_INT, x + 6);
      ep_accept(x + 7);
      wait_cyc(x + 13);

      // Reset while cfg_interrupt_n is low.
      burst4(last);
      push(EV_INT, last + 2);
      wait_cyc(last + 2);
      tx_frame_done = 1'b1;
      step();
      tx_frame_done = 1'b0;
      chk("pending_before_reset", 32'(pending_frames), 32'd1);
      reset = 1'b1;
      push(EV_DEASSERT, cyc + 1);
      step();
      chk("reset_mid_assert_cfg_n", 32'(ep_if.cfg_interrupt_n), 32'd1);
      chk("reset_mid_assert_pending", 32'(pending_frames), 32'd0);
      reset = 1'b0;
      step();
      step();

      // Saturation with no write ack.
      tx_frame_done = 1'b1;
      repeat (65534) step();
      chk("pending_below_sat", 32'(pending_frames), 32'd65534);
      repeat (6) step();
      tx_frame_done = 1'b0;
      chk("pending_saturated", 32'(pending_frames), 32'd65535);
      step();
      chk("pending_sat_hold", 32'(pending_frames), 32'd65535);
      repeat (5) step();

      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         n_checks++;
         n_err++;
         $display("FAIL missing_event actual=none required=%s@%0d", e.kind.name(), e.cyc);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
